// File: rtl/qa_shim_c0_read_arbiter.sv
// Shares one QLP channel-0 read path between two AFU requesters: per-port request
// FIFOs, round-robin grant, requester ID in the tag MSB, responses routed by that tag.
module qa_shim_c0_read_arbiter #(
  parameter int CCI_DATA_WIDTH   = 512,
  parameter int CCI_RX_HDR_WIDTH = 18,
  parameter int CCI_TX_HDR_WIDTH = 61,
  parameter int CCI_TAG_WIDTH    = 14,
  parameter int TX_TAG_LSB       = 0,
  parameter int RX_TAG_LSB       = 0,
  parameter int FIFO_DEPTH       = 8,
  parameter int ALMFULL_SLACK    = 4
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic [CCI_TX_HDR_WIDTH-1:0] a0_C0TxHdr,
  input  logic                        a0_C0TxRdValid,
  output logic                        a0_C0TxAlmFull,
  output logic [CCI_RX_HDR_WIDTH-1:0] a0_C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   a0_C0RxData,
  output logic                        a0_C0RxRdValid,

  input  logic [CCI_TX_HDR_WIDTH-1:0] a1_C0TxHdr,
  input  logic                        a1_C0TxRdValid,
  output logic                        a1_C0TxAlmFull,
  output logic [CCI_RX_HDR_WIDTH-1:0] a1_C0RxHdr,
  output logic [CCI_DATA_WIDTH-1:0]   a1_C0RxData,
  output logic                        a1_C0RxRdValid,

  output logic [CCI_TX_HDR_WIDTH-1:0] q_C0TxHdr,
  output logic                        q_C0TxRdValid,
  input  logic                        q_C0TxAlmFull,
  input  logic [CCI_RX_HDR_WIDTH-1:0] q_C0RxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]   q_C0RxData,
  input  logic                        q_C0RxRdValid
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int TX_MSB    = TX_TAG_LSB + CCI_TAG_WIDTH - 1;
  localparam int RX_MSB    = RX_TAG_LSB + CCI_TAG_WIDTH - 1;
  localparam int ALM_LEVEL = FIFO_DEPTH - ALMFULL_SLACK;

  logic [1:0]                  push;
  logic [CCI_TX_HDR_WIDTH-1:0] pushHdr [2];
  logic [CCI_TX_HDR_WIDTH-1:0] fifoMem [2][FIFO_DEPTH];
  logic [AW-1:0]               wrPtr [2];
  logic [AW-1:0]               rdPtr [2];
  logic [CW-1:0]               count [2];
  logic [CW-1:0]               countNext [2];
  logic [1:0]                  full;
  logic [1:0]                  nonEmpty;
  logic [1:0]                  accept;
  logic [1:0]                  pop;
  logic [1:0]                  almFull;
  logic                        lastGrant;
  logic                        popValid;
  logic                        popPort;
  logic [CCI_TX_HDR_WIDTH-1:0] popHdr;

  logic                        vld_p1;
  logic [CCI_TX_HDR_WIDTH-1:0] reqHdr_p1;
  logic [1:0]                  rspVld_p1;
  logic [CCI_RX_HDR_WIDTH-1:0] rspHdr_p1 [2];
  logic [CCI_DATA_WIDTH-1:0]   rspData_p1 [2];
  logic [CCI_RX_HDR_WIDTH-1:0] rxHdrClr;
  logic                        rxPort;

  assign push       = {a1_C0TxRdValid, a0_C0TxRdValid};
  assign pushHdr[0] = a0_C0TxHdr;
  assign pushHdr[1] = a1_C0TxHdr;

  // Stage p0: FIFO occupancy, round-robin pick and tag stamping
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]     = (count[i] == CW'(FIFO_DEPTH));
      nonEmpty[i] = (count[i] != '0);
      accept[i]   = push[i] && !full[i];
    end

    popValid = 1'b0;
    popPort  = 1'b0;
    if (!q_C0TxAlmFull) begin
      if (nonEmpty == 2'b11) begin
        popValid = 1'b1;
        popPort  = ~lastGrant;
      end else if (nonEmpty[0]) begin
        popValid = 1'b1;
        popPort  = 1'b0;
      end else if (nonEmpty[1]) begin
        popValid = 1'b1;
        popPort  = 1'b1;
      end
    end

    pop = popValid ? (popPort ? 2'b10 : 2'b01) : 2'b00;

    for (int i = 0; i < 2; i++) begin
      countNext[i] = count[i] + CW'(accept[i]) - CW'(pop[i]);
    end

    popHdr         = fifoMem[popPort][rdPtr[popPort]];
    popHdr[TX_MSB] = popPort;

    rxPort           = q_C0RxHdr[RX_MSB];
    rxHdrClr         = q_C0RxHdr;
    rxHdrClr[RX_MSB] = 1'b0;
  end

  // Stage p1: control state (pointers, counts, grant history, valids)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
        count[i] <= '0;
      end
      almFull   <= 2'b00;
      lastGrant <= 1'b1;
      vld_p1    <= 1'b0;
      rspVld_p1 <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        assert (!(push[i] && full[i]))
          else $warning("request FIFO %0d overflow, request dropped", i);
        if (accept[i]) wrPtr[i] <= wrPtr[i] + AW'(1);
        if (pop[i])    rdPtr[i] <= rdPtr[i] + AW'(1);
        count[i]   <= countNext[i];
        almFull[i] <= (countNext[i] >= CW'(ALM_LEVEL));
      end
      if (popValid) lastGrant <= popPort;
      vld_p1    <= popValid;
      rspVld_p1 <= {q_C0RxRdValid && rxPort, q_C0RxRdValid && !rxPort};
    end
  end

  // Stage p1: datapath registers, unreset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) fifoMem[i][wrPtr[i]] <= pushHdr[i];
    end
    if (popValid) reqHdr_p1 <= popHdr;
    if (q_C0RxRdValid) begin
      rspHdr_p1[rxPort]  <= rxHdrClr;
      rspData_p1[rxPort] <= q_C0RxData;
    end
  end

  assign q_C0TxRdValid  = vld_p1;
  assign q_C0TxHdr      = reqHdr_p1;
  assign a0_C0TxAlmFull = almFull[0];
  assign a1_C0TxAlmFull = almFull[1];
  assign a0_C0RxRdValid = rspVld_p1[0];
  assign a1_C0RxRdValid = rspVld_p1[1];
  assign a0_C0RxHdr     = rspHdr_p1[0];
  assign a1_C0RxHdr     = rspHdr_p1[1];
  assign a0_C0RxData    = rspData_p1[0];
  assign a1_C0RxData    = rspData_p1[1];

endmodule

// File: tb/tb_qa_shim_c0_read_arbiter.sv
// Bench for qa_shim_c0_read_arbiter: directed scenarios plus a randomized phase,
// all checked against a queue-based reference model of the arbiter's rules.
module tb_qa_shim_c0_read_arbiter;
  localparam int DW  = 512;
  localparam int RXW = 18;
  localparam int TXW = 61;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [TXW-1:0] a0Hdr, a1Hdr;
  logic           a0V, a1V;
  logic           a0Af, a1Af;
  logic [RXW-1:0] a0RHdr, a1RHdr;
  logic [DW-1:0]  a0RData, a1RData;
  logic           a0RV, a1RV;
  logic [TXW-1:0] qHdr;
  logic           qV;
  logic           qAf;
  logic [RXW-1:0] qRHdr;
  logic [DW-1:0]  qRData;
  logic           qRV;

  qa_shim_c0_read_arbiter dut (
    .clk(clk), .reset(reset),
    .a0_C0TxHdr(a0Hdr), .a0_C0TxRdValid(a0V), .a0_C0TxAlmFull(a0Af),
    .a0_C0RxHdr(a0RHdr), .a0_C0RxData(a0RData), .a0_C0RxRdValid(a0RV),
    .a1_C0TxHdr(a1Hdr), .a1_C0TxRdValid(a1V), .a1_C0TxAlmFull(a1Af),
    .a1_C0RxHdr(a1RHdr), .a1_C0RxData(a1RData), .a1_C0RxRdValid(a1RV),
    .q_C0TxHdr(qHdr), .q_C0TxRdValid(qV), .q_C0TxAlmFull(qAf),
    .q_C0RxHdr(qRHdr), .q_C0RxData(qRData), .q_C0RxRdValid(qRV)
  );

  // Reference model state
  logic [TXW-1:0] mq0[$], mq1[$];
  logic [TXW-1:0] seen[$];
  bit             lastG;
  bit             expQV, expAf0, expAf1, expRV0, expRV1;
  logic [TXW-1:0] expQHdr;
  logic [RXW-1:0] expRH0, expRH1;
  logic [DW-1:0]  expRD0, expRD1;
  int             nCmp, nBad;
  logic [DW-1:0]  dataD;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TXW-1:0] randHdr();
    logic [63:0]    t;
    logic [TXW-1:0] h;
    t     = {$urandom(), $urandom()};
    h     = t[TXW-1:0];
    h[13] = 1'b0;
    return h;
  endfunction

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Applies the arbiter's rules to the inputs present at this clock edge.
  task automatic modelEdge();
    bit             ne0, ne1, g, d0, d1;
    logic [TXW-1:0] h;
    logic [RXW-1:0] c;
    if (reset) begin
      mq0.delete(); mq1.delete();
      lastG = 1'b1;
      expQV = 0; expAf0 = 0; expAf1 = 0; expRV0 = 0; expRV1 = 0;
      return;
    end
    d0  = a0V && (mq0.size() == 8);
    d1  = a1V && (mq1.size() == 8);
    ne0 = mq0.size() > 0;
    ne1 = mq1.size() > 0;
    expQV = 0;
    if (!qAf && (ne0 || ne1)) begin
      g     = (ne0 && ne1) ? !lastG : !ne0;
      h     = g ? mq1.pop_front() : mq0.pop_front();
      h[13] = g;
      expQV = 1; expQHdr = h; lastG = g;
    end
    if (a0V && !d0) mq0.push_back(a0Hdr);
    if (a1V && !d1) mq1.push_back(a1Hdr);
    expAf0 = mq0.size() >= 4;
    expAf1 = mq1.size() >= 4;
    expRV0 = qRV && !qRHdr[13];
    expRV1 = qRV && qRHdr[13];
    if (qRV) begin
      c = qRHdr; c[13] = 1'b0;
      if (qRHdr[13]) begin expRH1 = c; expRD1 = qRData; end
      else begin expRH0 = c; expRD0 = qRData; end
    end
  endtask

  task automatic checkAll();
    chk("qValid", DW'(qV), DW'(expQV));
    if (expQV) chk("qHdr", DW'(qHdr), DW'(expQHdr));
    chk("a0AlmFull", DW'(a0Af), DW'(expAf0));
    chk("a1AlmFull", DW'(a1Af), DW'(expAf1));
    chk("a0RxValid", DW'(a0RV), DW'(expRV0));
    chk("a1RxValid", DW'(a1RV), DW'(expRV1));
    if (expRV0) begin
      chk("a0RxHdr", DW'(a0RHdr), DW'(expRH0));
      chk("a0RxData", a0RData, expRD0);
    end
    if (expRV1) begin
      chk("a1RxHdr", DW'(a1RHdr), DW'(expRH1));
      chk("a1RxData", a1RData, expRD1);
    end
    if (qV === 1'b1) seen.push_back(qHdr);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  initial begin
    nCmp = 0; nBad = 0; lastG = 1'b1;
    reset = 1'b1; a0V = 0; a1V = 0; a0Hdr = '0; a1Hdr = '0;
    qAf = 0; qRHdr = '0; qRData = '0; qRV = 0;
    repeat (3) tick();
    chk("rstQValid", DW'(qV), DW'(1'b0));
    chk("rstA0AlmFull", DW'(a0Af), DW'(1'b0));
    reset = 1'b0;
    repeat (6) tick();

    // Scenario 1: single a0 request, response routed to a0
    a0Hdr = randHdr(); a0Hdr[13:0] = 14'h0005; a0V = 1;
    tick(); a0V = 0;
    chk("t1QEarly", DW'(qV), DW'(1'b0));
    tick();
    chk("t1QValid", DW'(qV), DW'(1'b1));
    chk("t1QTag", DW'(qHdr[13:0]), DW'(14'h0005));
    qRHdr = {4'h3, 14'h0005}; qRData = randData(); qRV = 1;
    tick(); qRV = 0;
    chk("t1A0Valid", DW'(a0RV), DW'(1'b1));
    chk("t1A1Quiet", DW'(a1RV), DW'(1'b0));
    chk("t1A0Tag", DW'(a0RHdr[13:0]), DW'(14'h0005));
    tick();

    // Scenario 2: a1 request gets ID stamped; response returns with MSB cleared
    a1Hdr = randHdr(); a1Hdr[13:0] = 14'h0012; a1V = 1;
    tick(); a1V = 0;
    tick();
    chk("t2QTag", DW'(qHdr[13:0]), DW'(14'h2012));
    dataD = randData();
    qRHdr = {4'hA, 14'h2012}; qRData = dataD; qRV = 1;
    tick(); qRV = 0;
    chk("t2A1Valid", DW'(a1RV), DW'(1'b1));
    chk("t2A0Quiet", DW'(a0RV), DW'(1'b0));
    chk("t2A1Tag", DW'(a1RHdr[13:0]), DW'(14'h0012));
    chk("t2A1Data", a1RData, dataD);
    tick();

    // Scenario 3: both ports push every cycle
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      a0Hdr = randHdr(); a0Hdr[13:0] = 14'(16'h0100 + i); a0V = 1;
      a1Hdr = randHdr(); a1Hdr[13:0] = 14'(16'h0200 + i); a1V = 1;
      tick();
    end
    a0V = 0; a1V = 0;
    repeat (12) tick();
    chk("t3Count", DW'(seen.size()), DW'(16));
    for (int i = 0; i < 4; i++) chk("t3GrantOrder", DW'(seen[i][13]), DW'(i % 2));

    // Scenario 4: QLP back-pressure, a0 queues five then drains in order
    qAf = 1;
    for (int i = 0; i < 5; i++) begin
      a0Hdr = randHdr(); a0Hdr[13:0] = 14'(16'h0300 + i); a0V = 1;
      tick();
    end
    a0V = 0;
    chk("t4AlmFull", DW'(a0Af), DW'(1'b1));
    tick();
    qAf = 0; seen.delete();
    repeat (8) tick();
    chk("t4Count", DW'(seen.size()), DW'(5));
    for (int i = 0; i < 5; i++) chk("t4Order", DW'(seen[i][13:0]), DW'(14'(16'h0300 + i)));

    // Scenario 5: reset discards queued requests
    qAf = 1;
    for (int i = 0; i < 3; i++) begin
      a0Hdr = randHdr(); a0V = 1;
      tick();
    end
    a0V = 0; reset = 1;
    tick();
    reset = 0; qAf = 0;
    chk("t5QValid", DW'(qV), DW'(1'b0));
    chk("t5AlmFull", DW'(a0Af), DW'(1'b0));
    tick(); tick();
    chk("t5Discarded", DW'(qV), DW'(1'b0));
    a0Hdr = randHdr(); a0Hdr[13:0] = 14'h0777; a0V = 1;
    tick(); a0V = 0;
    tick();
    chk("t5Latency", DW'(qV), DW'(1'b1));
    chk("t5Tag", DW'(qHdr[13:0]), DW'(14'h0777));
    tick();

    // Scenario 6: ninth push into a full FIFO is dropped
    qAf = 1;
    for (int i = 0; i < 9; i++) begin
      a0Hdr = randHdr(); a0Hdr[13:0] = 14'(16'h0400 + i); a0V = 1;
      tick();
    end
    a0V = 0;
    tick();
    qAf = 0; seen.delete();
    repeat (12) tick();
    chk("t6Count", DW'(seen.size()), DW'(8));
    for (int i = 0; i < 8; i++) chk("t6Order", DW'(seen[i][13:0]), DW'(14'(16'h0400 + i)));

    // Randomized traffic within the FIFO limits
    for (int n = 0; n < 600; n++) begin
      a0V   = ($urandom_range(0, 2) == 0) && (mq0.size() < 8);
      a1V   = ($urandom_range(0, 2) == 0) && (mq1.size() < 8);
      a0Hdr = randHdr();
      a1Hdr = randHdr();
      qAf   = ($urandom_range(0, 3) == 0);
      qRV   = $urandom_range(0, 1) == 1;
      qRHdr = RXW'($urandom());
      qRData = randData();
      tick();
    end
    a0V = 0; a1V = 0; qAf = 0; qRV = 0;
    repeat (20) tick();
    chk("drainEmpty", DW'(qV), DW'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
